alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
// - Integer execution stage directly downstream of the ALU reservation station: takes one issued op per cycle
//   (workEn, operands, wrtTag, opCode, instAddr, instBranchTag) and broadcasts the result on the ALU write
//   port (enALUwrt/ALUtag/ALUdata) consumed by every RS line, the LS RS and the ROB/regfile.
// - Registers results one cycle, tracks the speculative branch tag of in-flight results and squashes them on misTaken.
// PARAMETERS
// - DATA_W   32  operand/result width (matches `DataBus)
// - TAG_W    5   rename tag width (matches `TagBus); TAG_FREE = all-zero tag means "no tag"
// - OP_W     6   opcode width (matches `OpBus); encodings are the `defines.v op macros
// - BTAG_W   4   branch-tag mask width (matches `BranchTagBus); bFreeNum indexes it
// PORTS
// - clk            in   1       single clock, rising edge
// - rst            in   1       asynchronous, active-high reset
// - rdy            in   1       global ready; when 0 all state holds (reset still acts)
// - ALUworkEn      in   1       valid op from ALU RS this cycle
// - operandO/T     in   DATA_W  source operands (already resolved)
// - wrtTag         in   TAG_W   destination rename tag
// - opCode         in   OP_W    operation
// - instAddr       in   DATA_W  instruction PC (for AUIPC/JAL/JALR link)
// - instBranchTag  in   BTAG_W  mask of unresolved branches this op depends on
// - bFreeEn        in   1       branch bFreeNum resolved
// - bFreeNum       in   2       index of resolved branch
// - misTaken       in   1       resolved branch mispredicted -> squash dependents
// - enALUwrt       out  1       result valid on write port
// - ALUtag         out  TAG_W   result tag (TAG_FREE when idle)
// - ALUdata        out  DATA_W  result value
// - ALUbusy        out  1       RS must not issue next cycle (only non-zero with ALU_MUL_EN)
// BEHAVIOUR
// - Reset: enALUwrt=0, ALUtag=TAG_FREE, ALUdata=0, ALUbusy=0, internal branch masks=0, all pipe valids=0.
// - Latency 1: op accepted at edge N (ALUworkEn=1, rdy=1) -> result visible after edge N+1, held exactly one cycle.
// - Ops: ADD/SUB/AND/OR/XOR/SLL/SRL/SRA (shift amount = operandT[4:0]), SLT/SLTU (result 0/1 zero-extended),
//   LUI -> operandT, AUIPC -> instAddr+operandT, JAL/JALR -> instAddr+4 (link only; target computed elsewhere).
//   All arithmetic modulo 2^DATA_W, no overflow flag. Unknown opcode -> result 0, still broadcast with its tag.
// - Result register holds a branch mask BM. Each cycle: if bFreeEn & BM[bFreeNum]: if misTaken, valid
//   cleared (squash, no broadcast); else BM[bFreeNum] cleared. Incoming op's mask is filtered the same way in
//   the same cycle, so an op issued during the resolving cycle is squashed/updated identically.
// - misTaken only acts when bFreeEn=1; misTaken with bFreeEn=0 is ignored.
// - ALUworkEn=0 -> next cycle enALUwrt=0, ALUtag=TAG_FREE (bubble), ALUdata don't-care but driven 0.
// - rdy=0: outputs and internal state frozen; an input op is not accepted (RS holds it since its state also freezes).
// - Reset mid-operation: all in-flight results dropped asynchronously; nothing broadcast after reset release until a new issue.
// CONFIGURATION
// - ALU_MUL_EN defined: adds MUL/MULH/MULHSU/MULHU as a 3-stage pipeline (accept at N, result after N+3), one
//   per cycle, each stage carrying tag+BM with the same squash/clear rule. When a MUL result and a simple result
//   complete in the same cycle, MUL wins the port; the simple result moves to a 1-entry hold register
//   (BM-tracked, squashable) and is broadcast next free cycle. ALUbusy=1 whenever the hold register is full or
//   a MUL will complete next cycle, so the RS issues nothing that could collide a second time.
// - ALU_MUL_EN undefined: MUL opcodes treated as unknown (result 0); no hold register; ALUbusy tied 0.
// TESTING
// - Reset: assert rst async mid-cycle with a valid result -> enALUwrt=0, ALUtag=TAG_FREE immediately.
// - ADD 0xFFFFFFFF+1, tag 5 at edge N -> edge N+1: enALUwrt=1, ALUtag=5, ALUdata=0; next cycle enALUwrt=0.
// - SRA 0x80000000 by operandT=0x21 -> 0xC0000000 (shamt 1); SLTU 1<0xFFFFFFFF -> 1; JAL at PC 0x100 -> 0x104.
// - Squash: issue tag 7 with BM=0010, next cycle bFreeEn=1,bFreeNum=1,misTaken=1 -> no broadcast of tag 7;
//   same with misTaken=0 -> broadcast tag 7, internal BM=0000.
// - rdy low 3 cycles with result pending -> outputs held constant, broadcast resumes on rdy high exactly once.
// - ALU_MUL_EN: MUL 7*6 tag 3 at N, ADD tag 4 at N+2 -> N+3 tag3=42, ALUbusy=1 at N+2..N+3, N+4 tag4.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: issue/resolve/write-port bundle between the ALU reservation
// station, the branch unit and the integer execution stage.
// master = issuing/observing side, slave = execution unit.
interface alu_exec_unit_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int OP_W   = 6,
    parameter int BTAG_W = 4
);
    logic              ALUworkEn;
    logic [DATA_W-1:0] operandO;
    logic [DATA_W-1:0] operandT;
    logic [TAG_W-1:0]  wrtTag;
    logic [OP_W-1:0]   opCode;
    logic [DATA_W-1:0] instAddr;
    logic [BTAG_W-1:0] instBranchTag;
    logic              bFreeEn;
    logic [1:0]        bFreeNum;
    logic              misTaken;
    logic              enALUwrt;
    logic [TAG_W-1:0]  ALUtag;
    logic [DATA_W-1:0] ALUdata;
    logic              ALUbusy;

    modport master (
        output ALUworkEn, operandO, operandT, wrtTag, opCode, instAddr, instBranchTag,
        output bFreeEn, bFreeNum, misTaken,
        input  enALUwrt, ALUtag, ALUdata, ALUbusy
    );

    modport slave (
        input  ALUworkEn, operandO, operandT, wrtTag, opCode, instAddr, instBranchTag,
        input  bFreeEn, bFreeNum, misTaken,
        output enALUwrt, ALUtag, ALUdata, ALUbusy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: integer execution stage behind the ALU reservation station.
// A simple op is computed into a branch-mask-tracked result register, then copied
// into the broadcast register that drives the shared write port for one cycle.
// Results depending on a mispredicted branch are squashed before broadcast.
// Optional feature macro: ALU_MUL_EN adds a 3-stage multiplier, a 1-entry hold
// register for the port collision and a non-zero ALUbusy.
module alu_exec_unit #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int OP_W   = 6,
    parameter int BTAG_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    alu_exec_unit_if.slave bus
);
    localparam logic [TAG_W-1:0] TAG_FREE = '0;

    localparam logic [OP_W-1:0] OP_LUI    = 6'd1;
    localparam logic [OP_W-1:0] OP_AUIPC  = 6'd2;
    localparam logic [OP_W-1:0] OP_JAL    = 6'd3;
    localparam logic [OP_W-1:0] OP_JALR   = 6'd4;
    localparam logic [OP_W-1:0] OP_ADD    = 6'd5;
    localparam logic [OP_W-1:0] OP_SUB    = 6'd6;
    localparam logic [OP_W-1:0] OP_SLL    = 6'd7;
    localparam logic [OP_W-1:0] OP_SLT    = 6'd8;
    localparam logic [OP_W-1:0] OP_SLTU   = 6'd9;
    localparam logic [OP_W-1:0] OP_XOR    = 6'd10;
    localparam logic [OP_W-1:0] OP_SRL    = 6'd11;
    localparam logic [OP_W-1:0] OP_SRA    = 6'd12;
    localparam logic [OP_W-1:0] OP_OR     = 6'd13;
    localparam logic [OP_W-1:0] OP_AND    = 6'd14;
`ifdef ALU_MUL_EN
    localparam logic [OP_W-1:0] OP_MUL    = 6'd15;
    localparam logic [OP_W-1:0] OP_MULH   = 6'd16;
    localparam logic [OP_W-1:0] OP_MULHSU = 6'd17;
    localparam logic [OP_W-1:0] OP_MULHU  = 6'd18;

    localparam logic [1:0] MS_LO  = 2'd0;
    localparam logic [1:0] MS_H   = 2'd1;
    localparam logic [1:0] MS_HSU = 2'd2;
    localparam logic [1:0] MS_HU  = 2'd3;
`endif

    // An entry dies when the branch being resolved now is one it depends on and it was mispredicted.
    function automatic logic bm_squash(input logic [BTAG_W-1:0] bm, input logic en,
                                       input logic [1:0] num, input logic mis);
        return en & bm[num] & mis;
    endfunction

    // A resolved branch no longer needs tracking, whatever the outcome.
    function automatic logic [BTAG_W-1:0] bm_clear(input logic [BTAG_W-1:0] bm, input logic en,
                                                   input logic [1:0] num);
        logic [BTAG_W-1:0] r;
        r = bm;
        if (en) begin
            r[num] = 1'b0;
        end else begin
            r = bm;
        end
        return r;
    endfunction

    logic [4:0]        shamt_s;
    logic [DATA_W-1:0] simple_res_s;
    logic              is_mul_s;
    logic              in_kill_s;
    logic [BTAG_W-1:0] in_bm_s;

    logic              ex_v_r;
    logic [TAG_W-1:0]  ex_tag_r;
    logic [DATA_W-1:0] ex_data_r;
    logic [BTAG_W-1:0] ex_bm_r;
    logic              ex_live_s;

    logic              out_v_s;
    logic [TAG_W-1:0]  out_tag_s;
    logic [DATA_W-1:0] out_data_s;
    logic              en_r;
    logic [TAG_W-1:0]  tag_r;
    logic [DATA_W-1:0] data_r;

    assign shamt_s   = bus.operandT[4:0];
    assign in_kill_s = bm_squash(bus.instBranchTag, bus.bFreeEn, bus.bFreeNum, bus.misTaken);
    assign in_bm_s   = bm_clear(bus.instBranchTag, bus.bFreeEn, bus.bFreeNum);
    assign ex_live_s = ex_v_r & ~bm_squash(ex_bm_r, bus.bFreeEn, bus.bFreeNum, bus.misTaken);

    // Simple-op result for the op presented by the reservation station this cycle.
    always_comb begin
        simple_res_s = '0;
        case (bus.opCode)
            OP_ADD:   simple_res_s = bus.operandO + bus.operandT;
            OP_SUB:   simple_res_s = bus.operandO - bus.operandT;
            OP_AND:   simple_res_s = bus.operandO & bus.operandT;
            OP_OR:    simple_res_s = bus.operandO | bus.operandT;
            OP_XOR:   simple_res_s = bus.operandO ^ bus.operandT;
            OP_SLL:   simple_res_s = bus.operandO << shamt_s;
            OP_SRL:   simple_res_s = bus.operandO >> shamt_s;
            OP_SRA:   simple_res_s = $unsigned($signed(bus.operandO) >>> shamt_s);
            OP_SLT:   simple_res_s = {{(DATA_W-1){1'b0}}, ($signed(bus.operandO) < $signed(bus.operandT))};
            OP_SLTU:  simple_res_s = {{(DATA_W-1){1'b0}}, (bus.operandO < bus.operandT)};
            OP_LUI:   simple_res_s = bus.operandT;
            OP_AUIPC: simple_res_s = bus.instAddr + bus.operandT;
            OP_JAL:   simple_res_s = bus.instAddr + {{(DATA_W-3){1'b0}}, 3'd4};
            OP_JALR:  simple_res_s = bus.instAddr + {{(DATA_W-3){1'b0}}, 3'd4};
            default:  simple_res_s = '0;
        endcase
    end

    // Result register for simple ops: capture accepted ops and apply branch resolution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v_r    <= 1'b0;
            ex_tag_r  <= TAG_FREE;
            ex_data_r <= '0;
            ex_bm_r   <= '0;
        end else if (rdy) begin
            ex_v_r    <= bus.ALUworkEn & ~is_mul_s & ~in_kill_s;
            ex_tag_r  <= bus.wrtTag;
            ex_data_r <= simple_res_s;
            ex_bm_r   <= in_bm_s;
        end
    end

`ifdef ALU_MUL_EN
    logic [1:0]          mul_sel_s;
    logic [DATA_W:0]     mul_a_s;
    logic [DATA_W:0]     mul_b_s;

    logic                m1_v_r, m2_v_r, m3_v_r;
    logic [TAG_W-1:0]    m1_tag_r, m2_tag_r, m3_tag_r;
    logic [BTAG_W-1:0]   m1_bm_r, m2_bm_r, m3_bm_r;
    logic [1:0]          m1_sel_r, m2_sel_r;
    logic [DATA_W:0]     m1_a_r, m1_b_r;
    logic [2*DATA_W-1:0] m2_prod_r;
    logic [DATA_W-1:0]   m3_res_r;
    logic                m1_live_s, m2_live_s, m3_live_s;

    logic                hold_v_r, hold_v_n;
    logic [TAG_W-1:0]    hold_tag_r, hold_tag_n;
    logic [DATA_W-1:0]   hold_data_r, hold_data_n;
    logic [BTAG_W-1:0]   hold_bm_r, hold_bm_n;
    logic                hold_live_s;
    logic                busy_r;

    assign m1_live_s   = m1_v_r & ~bm_squash(m1_bm_r, bus.bFreeEn, bus.bFreeNum, bus.misTaken);
    assign m2_live_s   = m2_v_r & ~bm_squash(m2_bm_r, bus.bFreeEn, bus.bFreeNum, bus.misTaken);
    assign m3_live_s   = m3_v_r & ~bm_squash(m3_bm_r, bus.bFreeEn, bus.bFreeNum, bus.misTaken);
    assign hold_live_s = hold_v_r & ~bm_squash(hold_bm_r, bus.bFreeEn, bus.bFreeNum, bus.misTaken);
    assign bus.ALUbusy = busy_r;

    // Multiply decode and operand extension (signedness of the high-half variants).
    always_comb begin
        is_mul_s  = 1'b0;
        mul_sel_s = MS_LO;
        case (bus.opCode)
            OP_MUL:    begin is_mul_s = 1'b1; mul_sel_s = MS_LO;  end
            OP_MULH:   begin is_mul_s = 1'b1; mul_sel_s = MS_H;   end
            OP_MULHSU: begin is_mul_s = 1'b1; mul_sel_s = MS_HSU; end
            OP_MULHU:  begin is_mul_s = 1'b1; mul_sel_s = MS_HU;  end
            default:   begin is_mul_s = 1'b0; mul_sel_s = MS_LO;  end
        endcase
        if ((mul_sel_s == MS_H) || (mul_sel_s == MS_HSU)) begin
            mul_a_s = {bus.operandO[DATA_W-1], bus.operandO};
        end else begin
            mul_a_s = {1'b0, bus.operandO};
        end
        if (mul_sel_s == MS_H) begin
            mul_b_s = {bus.operandT[DATA_W-1], bus.operandT};
        end else begin
            mul_b_s = {1'b0, bus.operandT};
        end
    end

    // Multiplier pipeline: operands, full product, selected half; each stage squashable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_v_r <= 1'b0; m2_v_r <= 1'b0; m3_v_r <= 1'b0;
            m1_tag_r <= TAG_FREE; m2_tag_r <= TAG_FREE; m3_tag_r <= TAG_FREE;
            m1_bm_r <= '0; m2_bm_r <= '0; m3_bm_r <= '0;
            m1_sel_r <= MS_LO; m2_sel_r <= MS_LO;
            m1_a_r <= '0; m1_b_r <= '0;
            m2_prod_r <= '0;
            m3_res_r <= '0;
        end else if (rdy) begin
            m1_v_r    <= bus.ALUworkEn & is_mul_s & ~in_kill_s;
            m1_tag_r  <= bus.wrtTag;
            m1_bm_r   <= in_bm_s;
            m1_sel_r  <= mul_sel_s;
            m1_a_r    <= mul_a_s;
            m1_b_r    <= mul_b_s;
            m2_v_r    <= m1_live_s;
            m2_tag_r  <= m1_tag_r;
            m2_bm_r   <= bm_clear(m1_bm_r, bus.bFreeEn, bus.bFreeNum);
            m2_sel_r  <= m1_sel_r;
            m2_prod_r <= {{(DATA_W-1){m1_a_r[DATA_W]}}, m1_a_r} * {{(DATA_W-1){m1_b_r[DATA_W]}}, m1_b_r};
            m3_v_r    <= m2_live_s;
            m3_tag_r  <= m2_tag_r;
            m3_bm_r   <= bm_clear(m2_bm_r, bus.bFreeEn, bus.bFreeNum);
            m3_res_r  <= (m2_sel_r == MS_LO) ? m2_prod_r[DATA_W-1:0] : m2_prod_r[2*DATA_W-1:DATA_W];
        end
    end

    // Hold register and busy flag: park a simple result that lost the port to a multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v_r    <= 1'b0;
            hold_tag_r  <= TAG_FREE;
            hold_data_r <= '0;
            hold_bm_r   <= '0;
            busy_r      <= 1'b0;
        end else if (rdy) begin
            hold_v_r    <= hold_v_n;
            hold_tag_r  <= hold_tag_n;
            hold_data_r <= hold_data_n;
            hold_bm_r   <= hold_bm_n;
            busy_r      <= hold_v_n | m2_live_s;
        end
    end
`else
    assign is_mul_s    = 1'b0;
    assign bus.ALUbusy = 1'b0;
`endif

    // Port arbitration: multiply first, then the parked result, then the fresh simple result.
    always_comb begin
        out_v_s    = 1'b0;
        out_tag_s  = TAG_FREE;
        out_data_s = '0;
`ifdef ALU_MUL_EN
        hold_v_n    = 1'b0;
        hold_tag_n  = hold_tag_r;
        hold_data_n = hold_data_r;
        hold_bm_n   = bm_clear(hold_bm_r, bus.bFreeEn, bus.bFreeNum);
        if (m3_live_s) begin
            out_v_s    = 1'b1;
            out_tag_s  = m3_tag_r;
            out_data_s = m3_res_r;
            if (hold_live_s) begin
                hold_v_n = 1'b1;
            end else if (ex_live_s) begin
                hold_v_n    = 1'b1;
                hold_tag_n  = ex_tag_r;
                hold_data_n = ex_data_r;
                hold_bm_n   = bm_clear(ex_bm_r, bus.bFreeEn, bus.bFreeNum);
            end else begin
                hold_v_n = 1'b0;
            end
        end else if (hold_live_s) begin
            out_v_s    = 1'b1;
            out_tag_s  = hold_tag_r;
            out_data_s = hold_data_r;
            if (ex_live_s) begin
                hold_v_n    = 1'b1;
                hold_tag_n  = ex_tag_r;
                hold_data_n = ex_data_r;
                hold_bm_n   = bm_clear(ex_bm_r, bus.bFreeEn, bus.bFreeNum);
            end else begin
                hold_v_n = 1'b0;
            end
        end else if (ex_live_s) begin
            out_v_s    = 1'b1;
            out_tag_s  = ex_tag_r;
            out_data_s = ex_data_r;
        end else begin
            out_v_s = 1'b0;
        end
`else
        if (ex_live_s) begin
            out_v_s    = 1'b1;
            out_tag_s  = ex_tag_r;
            out_data_s = ex_data_r;
        end else begin
            out_v_s = 1'b0;
        end
`endif
    end

    // Broadcast register: drives the shared write port for exactly one active cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r   <= 1'b0;
            tag_r  <= TAG_FREE;
            data_r <= '0;
        end else if (rdy) begin
            en_r   <= out_v_s;
            tag_r  <= out_tag_s;
            data_r <= out_data_s;
        end
    end

    assign bus.enALUwrt = en_r;
    assign bus.ALUtag   = tag_r;
    assign bus.ALUdata  = data_r;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table-driven vectors checked through an in-order scoreboard,
// plus hand-written sequences for latency, squash, freeze, reset and multiply timing.
module tb_alu_exec_unit;
    localparam logic [5:0] OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3, OP_JALR = 6'd4;
    localparam logic [5:0] OP_ADD = 6'd5, OP_SUB = 6'd6, OP_SLL = 6'd7, OP_SLT = 6'd8;
    localparam logic [5:0] OP_SLTU = 6'd9, OP_XOR = 6'd10, OP_SRL = 6'd11, OP_SRA = 6'd12;
    localparam logic [5:0] OP_OR = 6'd13, OP_AND = 6'd14, OP_MUL = 6'd15, OP_MULH = 6'd16;
    localparam logic [5:0] OP_MULHSU = 6'd17, OP_MULHU = 6'd18, OP_BAD = 6'd63;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    vec_t vecs[$];
    res_t sbq[$];

    alu_exec_unit_if bus();

    alu_exec_unit dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [4:0] tag, input logic [3:0] bm);
        bus.ALUworkEn     = 1'b1;
        bus.opCode        = op;
        bus.operandO      = a;
        bus.operandT      = b;
        bus.instAddr      = pc;
        bus.wrtTag        = tag;
        bus.instBranchTag = bm;
    endtask

    task automatic idle();
        bus.ALUworkEn     = 1'b0;
        bus.opCode        = 6'd0;
        bus.operandO      = 32'd0;
        bus.operandT      = 32'd0;
        bus.instAddr      = 32'd0;
        bus.wrtTag        = 5'd0;
        bus.instBranchTag = 4'd0;
    endtask

    task automatic bfree(input logic en, input logic [1:0] num, input logic mis);
        bus.bFreeEn  = en;
        bus.bFreeNum = num;
        bus.misTaken = mis;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic en, input logic [4:0] tag, input logic [31:0] data);
        chk({name, "_en"}, 32'(bus.enALUwrt), 32'(en));
        chk({name, "_tag"}, 32'(bus.ALUtag), 32'(tag));
        chk({name, "_data"}, bus.ALUdata, data);
    endtask

    // Scoreboard monitor: every broadcast must match the oldest expected result.
    always @(negedge clk) begin
        res_t e;
        if (mon_en && (bus.enALUwrt === 1'b1)) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_spurious: got tag %0h with nothing expected", bus.ALUtag);
            end else begin
                e = sbq.pop_front();
                chk("sb_tag", 32'(bus.ALUtag), 32'(e.tag));
                chk("sb_data", bus.ALUdata, e.data);
            end
        end
    end

    initial begin
        vecs.push_back('{OP_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         32'h0000_0000});
        vecs.push_back('{OP_SUB,   32'h0000_0005, 32'h0000_0007, 32'h0,         32'hFFFF_FFFE});
        vecs.push_back('{OP_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0,         32'h00F0_00F0});
        vecs.push_back('{OP_OR,    32'h1234_0000, 32'h0000_5678, 32'h0,         32'h1234_5678});
        vecs.push_back('{OP_XOR,   32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0,         32'hF0F0_0F0F});
        vecs.push_back('{OP_SLL,   32'h0000_0001, 32'h0000_0024, 32'h0,         32'h0000_0010});
        vecs.push_back('{OP_SRL,   32'h8000_0000, 32'h0000_0021, 32'h0,         32'h4000_0000});
        vecs.push_back('{OP_SRA,   32'h8000_0000, 32'h0000_0021, 32'h0,         32'hC000_0000});
        vecs.push_back('{OP_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         32'h0000_0001});
        vecs.push_back('{OP_SLTU,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0,         32'h0000_0001});
        vecs.push_back('{OP_SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         32'h0000_0000});
        vecs.push_back('{OP_LUI,   32'h1111_1111, 32'hABCD_E000, 32'h0,         32'hABCD_E000});
        vecs.push_back('{OP_AUIPC, 32'h0,         32'h0000_2000, 32'h0000_1000, 32'h0000_3000});
        vecs.push_back('{OP_JAL,   32'h5,         32'h6,         32'h0000_0100, 32'h0000_0104});
        vecs.push_back('{OP_JALR,  32'h5,         32'h6,         32'hFFFF_FFFC, 32'h0000_0000});
        vecs.push_back('{OP_BAD,   32'h1234_5678, 32'h1,         32'h0,         32'h0000_0000});
`ifndef ALU_MUL_EN
        vecs.push_back('{OP_MUL,   32'h0000_0007, 32'h0000_0006, 32'h0,         32'h0000_0000});
`endif

        rst = 1'b1;
        rdy = 1'b1;
        idle();
        bfree(1'b0, 2'd0, 1'b0);
        #12;
        chk_out("reset", 1'b0, 5'd0, 32'd0);
        chk("reset_busy", 32'(bus.ALUbusy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // latency and single-cycle broadcast
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd5, 4'b0000);
        tick();
        idle();
        chk("lat_early_en", 32'(bus.enALUwrt), 32'd0);
        tick();
        chk_out("lat", 1'b1, 5'd5, 32'd0);
        tick();
        chk_out("lat_bubble", 1'b0, 5'd0, 32'd0);

        // back-to-back table through the scoreboard
        mon_en = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, 5'(i + 1), 4'b0000);
            sbq.push_back('{5'(i + 1), vecs[i].exp});
            tick();
        end
        idle();
        repeat (3) tick();
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        mon_en = 1'b0;

        // squash on misprediction of a tracked branch
        issue(OP_ADD, 32'h1, 32'h1, 32'h0, 5'd7, 4'b0010);
        tick();
        idle();
        bfree(1'b1, 2'd1, 1'b1);
        tick();
        bfree(1'b0, 2'd0, 1'b0);
        chk_out("squash", 1'b0, 5'd0, 32'd0);

        // correct prediction keeps the result
        issue(OP_ADD, 32'h1, 32'h1, 32'h0, 5'd7, 4'b0010);
        tick();
        idle();
        bfree(1'b1, 2'd1, 1'b0);
        tick();
        bfree(1'b0, 2'd0, 1'b0);
        chk_out("resolve_ok", 1'b1, 5'd7, 32'd2);

        // op issued in the resolving cycle is squashed too
        issue(OP_ADD, 32'h1, 32'h1, 32'h0, 5'd10, 4'b0100);
        bfree(1'b1, 2'd2, 1'b1);
        tick();
        idle();
        bfree(1'b0, 2'd0, 1'b0);
        tick();
        chk("squash_in_en", 32'(bus.enALUwrt), 32'd0);

        // misTaken without bFreeEn is ignored
        issue(OP_ADD, 32'h2, 32'h2, 32'h0, 5'd11, 4'b0001);
        tick();
        idle();
        bfree(1'b0, 2'd0, 1'b1);
        tick();
        bfree(1'b0, 2'd0, 1'b0);
        chk_out("mis_no_en", 1'b1, 5'd11, 32'd4);

        // mispredict of an unrelated branch leaves the result alone
        issue(OP_ADD, 32'h3, 32'h3, 32'h0, 5'd12, 4'b0001);
        tick();
        idle();
        bfree(1'b1, 2'd2, 1'b1);
        tick();
        bfree(1'b0, 2'd0, 1'b0);
        chk_out("other_br", 1'b1, 5'd12, 32'd6);

        // rdy low with a result pending: outputs frozen, pending result broadcast once
        issue(OP_ADD, 32'h2, 32'h3, 32'h0, 5'd13, 4'b0000);
        tick();
        issue(OP_SUB, 32'h9, 32'h2, 32'h0, 5'd14, 4'b0000);
        tick();
        idle();
        rdy = 1'b0;
        chk_out("frz_pre", 1'b1, 5'd13, 32'd5);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("frz_hold", 1'b1, 5'd13, 32'd5);
        end
        rdy = 1'b1;
        tick();
        chk_out("frz_resume", 1'b1, 5'd14, 32'd7);
        tick();
        chk("frz_once_en", 32'(bus.enALUwrt), 32'd0);

        // asynchronous reset drops visible and in-flight results
        issue(OP_ADD, 32'h10, 32'h10, 32'h0, 5'd20, 4'b0000);
        tick();
        issue(OP_ADD, 32'h20, 32'h20, 32'h0, 5'd21, 4'b0000);
        tick();
        idle();
        chk_out("rst_pre", 1'b1, 5'd20, 32'h20);
        #3;
        rst = 1'b1;
        #1;
        chk_out("rst_async", 1'b0, 5'd0, 32'd0);
        #2;
        rst = 1'b0;
        tick();
        chk("rst_drop1_en", 32'(bus.enALUwrt), 32'd0);
        tick();
        chk("rst_drop2_en", 32'(bus.enALUwrt), 32'd0);

`ifdef ALU_MUL_EN
        // multiply collides with a later simple op: multiply wins, simple op follows
        issue(OP_MUL, 32'd7, 32'd6, 32'h0, 5'd3, 4'b0000);
        tick();
        idle();
        chk("mul_busy_n", 32'(bus.ALUbusy), 32'd0);
        tick();
        chk("mul_busy_n1", 32'(bus.ALUbusy), 32'd0);
        issue(OP_ADD, 32'd1, 32'd1, 32'h0, 5'd4, 4'b0000);
        tick();
        idle();
        chk("mul_busy_n2", 32'(bus.ALUbusy), 32'd1);
        chk("mul_n2_en", 32'(bus.enALUwrt), 32'd0);
        tick();
        chk_out("mul_n3", 1'b1, 5'd3, 32'd42);
        chk("mul_busy_n3", 32'(bus.ALUbusy), 32'd1);
        tick();
        chk_out("mul_n4", 1'b1, 5'd4, 32'd2);
        chk("mul_busy_n4", 32'(bus.ALUbusy), 32'd0);
        tick();
        chk("mul_n5_en", 32'(bus.enALUwrt), 32'd0);

        // multiply variants
        begin
            vec_t mv[4];
            mv[0] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE};
            mv[1] = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000};
            mv[2] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
            mv[3] = '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_0001};
            for (int j = 0; j < 4; j++) begin
                issue(mv[j].op, mv[j].a, mv[j].b, 32'h0, 5'(j + 24), 4'b0000);
                tick();
                idle();
                repeat (3) tick();
                chk_out("mul_var", 1'b1, 5'(j + 24), mv[j].exp);
            end
        end

        // multiply squashed mid-pipeline
        issue(OP_MUL, 32'd3, 32'd3, 32'h0, 5'd9, 4'b1000);
        tick();
        idle();
        bfree(1'b1, 2'd3, 1'b1);
        tick();
        bfree(1'b0, 2'd0, 1'b0);
        tick();
        tick();
        chk("mul_squash_en", 32'(bus.enALUwrt), 32'd0);
`else
        issue(OP_MUL, 32'd7, 32'd6, 32'h0, 5'd3, 4'b0000);
        tick();
        idle();
        chk("nomul_busy", 32'(bus.ALUbusy), 32'd0);
        tick();
        chk_out("nomul", 1'b1, 5'd3, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
